mmio_bus_fabric: RTL and testbench
==================================

Name: mmio_bus_fabric

Overview:
- Parametrised memory-mapped interconnect between NUM_MASTERS bus masters (CPU data port, VGA pixel fetch, future DMA) and two slaves: the RAM block and the IO block.
- Decodes each request by address prefix and arbitrates round-robin, one transaction per cycle.
- Steers read data back with the slaves' one-cycle synchronous read latency tracked by registered tags, so the read mux is selected by the address of the previous cycle.
- Replaces the ad-hoc combinational prefix muxes at the top level.

Parameters:
- DATA_W, 16, data word width.
- ADDR_W, 16, byte-address width seen by masters and slaves.
- NUM_MASTERS, 2, number of master ports (1..8).
- IO_PREFIX_W, 2, number of top address bits used for decode.
- IO_PREFIX, 2'b11, prefix value that selects the IO block; all other values select RAM.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- m_req  in  NUM_MASTERS  per-master request.
- m_we  in  NUM_MASTERS  per-master write enable; 1 = write, 0 = read.
- m_addr  in  NUM_MASTERS*ADDR_W  packed addresses; master i occupies bits [i*ADDR_W +: ADDR_W].
- m_wdata  in  NUM_MASTERS*DATA_W  packed write data, same packing.
- m_gnt  out  NUM_MASTERS  one-hot (or zero) grant, combinational, same cycle as the request.
- m_rvalid  out  NUM_MASTERS  one-hot read-data-valid, one cycle after a granted read.
- m_rdata  out  DATA_W  shared read data; meaningful only while an m_rvalid bit is high.
- ram_addr  out  ADDR_W  RAM address.
- ram_we  out  1  RAM write strobe.
- ram_wdata  out  DATA_W  RAM write data.
- ram_rdata  in  DATA_W  RAM read data, registered by the RAM; one-cycle latency.
- io_addr  out  ADDR_W  IO address.
- io_we  out  1  IO write strobe.
- io_wdata  out  DATA_W  IO write data.
- io_rdata  in  DATA_W  IO read data, one-cycle latency.
- busy_cnt  out  8  saturating count of cycles in which at least one requester was denied (contention monitor).

Behaviour:
- Reset: ptr = 0, rvalid tags cleared, m_gnt = 0, m_rvalid = 0, m_rdata = 0, both we = 0, both addr/wdata = 0, busy_cnt = 0.
- Arbitration (combinational): grant the first requesting master at or after ptr, searching upward modulo NUM_MASTERS. At most one grant per cycle. With no requests: m_gnt = 0, both we = 0.
- Pointer update: on any grant, ptr <= (granted index + 1) mod NUM_MASTERS; otherwise ptr holds. A sole requester is granted every cycle.
- Decode: sel_io = (addr[ADDR_W-1 -: IO_PREFIX_W] == IO_PREFIX).
  - The granted address and wdata drive both slaves.
  - Only the selected slave receives we = m_we[granted].
  - The unselected slave's we = 0.
  - Idle cycles drive addr and wdata = 0.
- Writes: complete at the grant edge; no m_rvalid is produced.
- Reads, pipeline register at the grant edge: rtag_valid <= 1, rtag_master <= granted index, rtag_io <= sel_io.
- Read return, next cycle: m_rvalid[rtag_master] = rtag_valid; m_rdata = rtag_io ? io_rdata : ram_rdata, combinational from the tag. When rtag_valid = 0, m_rdata = 0.
- Back-to-back: a read granted in cycle N returns in N+1 while a new request is granted in N+1. Full throughput is one transaction per cycle.
- A granted read to IO followed by a read to RAM must each return the correct slave's data (the tag pipeline is mandatory).
- Masters must hold m_req, m_we, m_addr and m_wdata stable until they see m_gnt. The fabric does not buffer requests.
- busy_cnt increments (saturating at 255) on each cycle where popcount(m_req) > 1.
- Reset asserted mid-read: the pending rvalid is dropped and the next cycle shows m_rvalid = 0. Slave we is forced to 0 during reset even if m_req is high.
- Out-of-range packed indices cannot occur; NUM_MASTERS = 1 degenerates to a pass-through with the tag pipeline.

Decomposition:
- Shared package mmio_pkg holds:
  - IO_PREFIX and IO_PREFIX_W defaults,
  - region enum (REGION_RAM = 0, REGION_IO = 1),
  - $clog2(NUM_MASTERS) index-width helper constant.
- Sub-module rr_arbiter (parameter N):
  - inputs: req, advance;
  - outputs: one-hot gnt, binary gnt_idx;
  - owns ptr.
- Decode, slave steering, tag pipeline and busy_cnt stay in mmio_bus_fabric.

Test Plan:
- Reset: hold reset 2 cycles with m_req = 2'b11 -> m_gnt = 0, both we = 0, m_rvalid = 0, busy_cnt = 0.
- Single master read:
  - stimulus: m0 reads 0x0040 (RAM), ram_rdata = 0x1234 next cycle;
  - response: m_gnt = 01 in cycle N, m_rvalid = 01 and m_rdata = 0x1234 in N+1.
- IO routing:
  - stimulus: m1 writes 0xBEEF to 0xC010;
  - response: io_we = 1, io_addr = 0xC010, io_wdata = 0xBEEF, ram_we = 0, no rvalid.
- Round-robin:
  - stimulus: both masters request reads continuously for 4 cycles from reset;
  - response: grants 01, 10, 01, 10; busy_cnt = 4.
- Interleaved regions:
  - stimulus: m0 reads 0xC000 (io_rdata = 0x00AA), then immediately reads 0x0010 (ram_rdata = 0x5555);
  - response: rdata 0x00AA then 0x5555 on consecutive cycles.
- Reset mid-read:
  - stimulus: grant a read, assert reset the following cycle;
  - response: m_rvalid stays 0; after reset release, m1 is granted first only if m0 is idle (ptr = 0).

Source files
------------

// File: rtl/mmio_bus_fabric_pkg.sv
// Shared definitions for the MMIO fabric: decode defaults, region encoding
// and the master-index width helper.
package mmio_pkg;

    localparam int IO_PREFIX_W_DEFAULT = 2;
    localparam logic [1:0] IO_PREFIX_DEFAULT = 2'b11;

    typedef enum logic {
        REGION_RAM = 1'b0,
        REGION_IO  = 1'b1
    } region_e;

    // A single master still needs a one-bit index so the tag register exists.
    function automatic int idxWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mmio_bus_fabric_if.sv
// Bus bundle between the masters/slaves and the fabric; "master" is the
// environment side, "slave" is the fabric side.
interface mmio_bus_fabric_if #(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 16,
    parameter int NUM_MASTERS = 2
);
    logic [NUM_MASTERS-1:0]        m_req;
    logic [NUM_MASTERS-1:0]        m_we;
    logic [NUM_MASTERS*ADDR_W-1:0] m_addr;
    logic [NUM_MASTERS*DATA_W-1:0] m_wdata;
    logic [NUM_MASTERS-1:0]        m_gnt;
    logic [NUM_MASTERS-1:0]        m_rvalid;
    logic [DATA_W-1:0]             m_rdata;
    logic [ADDR_W-1:0]             ram_addr;
    logic                          ram_we;
    logic [DATA_W-1:0]             ram_wdata;
    logic [DATA_W-1:0]             ram_rdata;
    logic [ADDR_W-1:0]             io_addr;
    logic                          io_we;
    logic [DATA_W-1:0]             io_wdata;
    logic [DATA_W-1:0]             io_rdata;

    modport master (
        output m_req, m_we, m_addr, m_wdata, ram_rdata, io_rdata,
        input  m_gnt, m_rvalid, m_rdata,
        input  ram_addr, ram_we, ram_wdata, io_addr, io_we, io_wdata
    );

    modport slave (
        input  m_req, m_we, m_addr, m_wdata, ram_rdata, io_rdata,
        output m_gnt, m_rvalid, m_rdata,
        output ram_addr, ram_we, ram_wdata, io_addr, io_we, io_wdata
    );
endinterface

// File: rtl/mmio_bus_fabric_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after ptr and moves
// ptr just past the winner whenever a grant is taken.
module rr_arbiter
    import mmio_pkg::*;
#(
    parameter int N  = 2,
    parameter int IW = idxWidth(N)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [N-1:0]  req,
    input  logic          advance,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx
);

    logic [IW-1:0] ptr_r;
    logic          found_s;
    logic [IW-1:0] nextPtr_s;

    // Search upward from ptr, wrapping modulo N; first hit wins.
    always_comb begin
        gnt       = {N{1'b0}};
        gnt_idx   = {IW{1'b0}};
        found_s   = 1'b0;
        for (int i = 0; i < N; i++) begin
            logic [IW-1:0] cand;
            cand = IW'((int'(ptr_r) + i) % N);
            if (!found_s && req[cand]) begin
                found_s      = 1'b1;
                gnt[cand]    = 1'b1;
                gnt_idx      = cand;
            end else begin
                found_s = found_s;
            end
        end
        if (gnt_idx == IW'(N - 1)) begin
            nextPtr_s = {IW{1'b0}};
        end else begin
            nextPtr_s = gnt_idx + IW'(1);
        end
    end

    // Pointer register.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_r <= {IW{1'b0}};
        end else if (advance && found_s) begin
            ptr_r <= nextPtr_s;
        end else begin
            ptr_r <= ptr_r;
        end
    end

endmodule

// File: rtl/mmio_bus_fabric.sv
// MMIO interconnect: round-robin master arbitration, prefix decode to RAM/IO,
// and a one-deep read tag so returning data is steered by last cycle's address.
module mmio_bus_fabric
    import mmio_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 16,
    parameter int NUM_MASTERS = 2,
    parameter int IO_PREFIX_W = IO_PREFIX_W_DEFAULT,
    parameter logic [IO_PREFIX_W-1:0] IO_PREFIX = IO_PREFIX_W'(IO_PREFIX_DEFAULT)
) (
    input  logic                clk,
    input  logic                reset,
    mmio_bus_fabric_if.slave    bus,
    output logic [7:0]          busy_cnt
);

    localparam int IW = idxWidth(NUM_MASTERS);

    logic [NUM_MASTERS-1:0] arbGnt_s;
    logic [IW-1:0]          gntIdx_s;
    logic                   anyGnt_s;
    logic [ADDR_W-1:0]      grantAddr_s;
    logic [DATA_W-1:0]      grantData_s;
    logic                   grantWe_s;
    region_e                region_s;

    logic                   rtagValid_r;
    logic [IW-1:0]          rtagMaster_r;
    region_e                rtagRegion_r;
    logic [7:0]             busyCnt_r;

    rr_arbiter #(.N(NUM_MASTERS), .IW(IW)) u_arb (
        .clk     (clk),
        .reset   (reset),
        .req     (bus.m_req),
        .advance (~reset),
        .gnt     (arbGnt_s),
        .gnt_idx (gntIdx_s)
    );

    // Grant gating, request mux, decode and slave steering.
    always_comb begin
        anyGnt_s    = ~reset & (|arbGnt_s);
        grantAddr_s = {ADDR_W{1'b0}};
        grantData_s = {DATA_W{1'b0}};
        grantWe_s   = 1'b0;
        if (anyGnt_s) begin
            bus.m_gnt   = arbGnt_s;
            grantAddr_s = bus.m_addr[int'(gntIdx_s)*ADDR_W +: ADDR_W];
            grantData_s = bus.m_wdata[int'(gntIdx_s)*DATA_W +: DATA_W];
            grantWe_s   = bus.m_we[gntIdx_s];
        end else begin
            bus.m_gnt   = {NUM_MASTERS{1'b0}};
        end
        region_s      = (grantAddr_s[ADDR_W-1 -: IO_PREFIX_W] == IO_PREFIX) ? REGION_IO : REGION_RAM;
        bus.ram_addr  = grantAddr_s;
        bus.io_addr   = grantAddr_s;
        bus.ram_wdata = grantData_s;
        bus.io_wdata  = grantData_s;
        bus.ram_we    = grantWe_s & (region_s == REGION_RAM);
        bus.io_we     = grantWe_s & (region_s == REGION_IO);
    end

    // Read tag pipeline: remembers who asked and which slave answers next cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            rtagValid_r  <= 1'b0;
            rtagMaster_r <= {IW{1'b0}};
            rtagRegion_r <= REGION_RAM;
        end else begin
            rtagValid_r  <= anyGnt_s & ~grantWe_s;
            rtagMaster_r <= gntIdx_s;
            rtagRegion_r <= region_s;
        end
    end

    // Read return; reset masks a pending tag so nothing leaks out.
    always_comb begin
        if (rtagValid_r && !reset) begin
            bus.m_rvalid = NUM_MASTERS'(1'b1) << rtagMaster_r;
            bus.m_rdata  = (rtagRegion_r == REGION_IO) ? bus.io_rdata : bus.ram_rdata;
        end else begin
            bus.m_rvalid = {NUM_MASTERS{1'b0}};
            bus.m_rdata  = {DATA_W{1'b0}};
        end
    end

    // Contention monitor, saturating.
    always_ff @(posedge clk) begin
        if (reset) begin
            busyCnt_r <= 8'd0;
        end else if (($countones(bus.m_req) > 1) && (busyCnt_r != 8'hFF)) begin
            busyCnt_r <= busyCnt_r + 8'd1;
        end else begin
            busyCnt_r <= busyCnt_r;
        end
    end

    assign busy_cnt = busyCnt_r;

endmodule

// File: tb/tb_mmio_bus_fabric.sv
// Directed bench for mmio_bus_fabric: read returns go through a scoreboard
// queue checked by a monitor; grants and slave strobes are checked inline.
module tb_mmio_bus_fabric;

    localparam int DW = 16;
    localparam int AW = 16;
    localparam int NM = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] busy_cnt;

    mmio_bus_fabric_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_MASTERS(NM)) bus ();

    mmio_bus_fabric #(.DATA_W(DW), .ADDR_W(AW), .NUM_MASTERS(NM)) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .busy_cnt (busy_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic        master;
        logic [15:0] data;
    } exp_t;
    exp_t expQ[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", name, act, want);
        end
    endtask

    // Slave models: one-cycle registered read, write at the strobe edge.
    logic [15:0] ramMem[256];
    logic [15:0] ioMem[256];
    always @(posedge clk) begin
        if (reset) begin
            ramMem[8'h40] <= 16'h1234;
            ramMem[8'h42] <= 16'h4242;
            ramMem[8'h10] <= 16'h5555;
            ioMem[8'h00]  <= 16'h00AA;
        end else begin
            if (bus.ram_we) ramMem[bus.ram_addr[7:0]] <= bus.ram_wdata;
            if (bus.io_we)  ioMem[bus.io_addr[7:0]]   <= bus.io_wdata;
        end
        bus.ram_rdata <= ramMem[bus.ram_addr[7:0]];
        bus.io_rdata  <= ioMem[bus.io_addr[7:0]];
    end

    // Monitor: every read-valid must match the head of the scoreboard.
    always @(negedge clk) begin
        if (bus.m_rvalid != 2'b00) begin
            if (expQ.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_rvalid: got=%b want=none", bus.m_rvalid);
            end else begin
                exp_t e;
                logic [1:0] one;
                e   = expQ.pop_front();
                one = 2'b01;
                check("rvalid", 32'(bus.m_rvalid), 32'(one << e.master));
                check("rdata", 32'(bus.m_rdata), 32'(e.data));
            end
        end
    end

    task automatic go(input logic rst, input logic [1:0] req, input logic [1:0] we,
                      input logic [15:0] a0, input logic [15:0] a1,
                      input logic [15:0] d0, input logic [15:0] d1);
        @(posedge clk);
        #1;
        reset       = rst;
        bus.m_req   = req;
        bus.m_we    = we;
        bus.m_addr  = {a1, a0};
        bus.m_wdata = {d1, d0};
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        reset       = 1'b1;
        bus.m_req   = 2'b11;
        bus.m_we    = 2'b00;
        bus.m_addr  = {16'h0042, 16'h0040};
        bus.m_wdata = 32'h0;

        // Reset held two cycles with both masters requesting.
        go(1'b1, 2'b11, 2'b00, 16'h0040, 16'h0042, 16'h0, 16'h0);
        go(1'b1, 2'b11, 2'b00, 16'h0040, 16'h0042, 16'h0, 16'h0);
        check("rst_gnt", 32'(bus.m_gnt), 32'h0);
        check("rst_ram_we", 32'(bus.ram_we), 32'h0);
        check("rst_io_we", 32'(bus.io_we), 32'h0);
        check("rst_rvalid", 32'(bus.m_rvalid), 32'h0);
        check("rst_busy", 32'(busy_cnt), 32'h0);

        // Round-robin: both read continuously for four cycles.
        for (int i = 0; i < 4; i++) begin
            go(1'b0, 2'b11, 2'b00, 16'h0040, 16'h0042, 16'h0, 16'h0);
            check("rr_gnt", 32'(bus.m_gnt), (i % 2 == 0) ? 32'h1 : 32'h2);
            if (i % 2 == 0) expQ.push_back('{master: 1'b0, data: 16'h1234});
            else            expQ.push_back('{master: 1'b1, data: 16'h4242});
        end
        go(1'b0, 2'b00, 2'b00, 16'h0, 16'h0, 16'h0, 16'h0);
        check("rr_busy", 32'(busy_cnt), 32'd4);
        check("idle_gnt", 32'(bus.m_gnt), 32'h0);
        check("idle_addr", 32'(bus.ram_addr), 32'h0);

        // Single master read from RAM.
        go(1'b0, 2'b01, 2'b00, 16'h0040, 16'h0, 16'h0, 16'h0);
        check("single_gnt", 32'(bus.m_gnt), 32'h1);
        expQ.push_back('{master: 1'b0, data: 16'h1234});

        // IO write from master 1.
        go(1'b0, 2'b10, 2'b10, 16'h0, 16'hC010, 16'h0, 16'hBEEF);
        check("iow_gnt", 32'(bus.m_gnt), 32'h2);
        check("iow_io_we", 32'(bus.io_we), 32'h1);
        check("iow_io_addr", 32'(bus.io_addr), 32'hC010);
        check("iow_io_wdata", 32'(bus.io_wdata), 32'hBEEF);
        check("iow_ram_we", 32'(bus.ram_we), 32'h0);

        // Interleaved regions: IO read then RAM read back to back.
        go(1'b0, 2'b01, 2'b00, 16'hC000, 16'h0, 16'h0, 16'h0);
        check("ilv_gnt0", 32'(bus.m_gnt), 32'h1);
        check("ilv_norv", 32'(bus.m_rvalid), 32'h0);
        expQ.push_back('{master: 1'b0, data: 16'h00AA});
        go(1'b0, 2'b01, 2'b00, 16'h0010, 16'h0, 16'h0, 16'h0);
        check("ilv_gnt1", 32'(bus.m_gnt), 32'h1);
        expQ.push_back('{master: 1'b0, data: 16'h5555});

        // Read back the earlier IO write through master 1.
        go(1'b0, 2'b10, 2'b00, 16'h0, 16'hC010, 16'h0, 16'h0);
        check("rb_gnt", 32'(bus.m_gnt), 32'h2);
        expQ.push_back('{master: 1'b1, data: 16'hBEEF});

        // Reset mid-read: granted read must never return.
        go(1'b0, 2'b01, 2'b00, 16'h0040, 16'h0, 16'h0, 16'h0);
        check("mid_gnt", 32'(bus.m_gnt), 32'h1);
        go(1'b1, 2'b01, 2'b01, 16'h0040, 16'h0, 16'hDEAD, 16'h0);
        check("mid_rvalid", 32'(bus.m_rvalid), 32'h0);
        check("mid_ram_we", 32'(bus.ram_we), 32'h0);
        check("mid_gnt_rst", 32'(bus.m_gnt), 32'h0);

        // After release ptr is back to 0, so master 0 wins a tie.
        go(1'b0, 2'b11, 2'b00, 16'h0010, 16'hC000, 16'h0, 16'h0);
        check("post_gnt0", 32'(bus.m_gnt), 32'h1);
        expQ.push_back('{master: 1'b0, data: 16'h5555});
        go(1'b0, 2'b10, 2'b00, 16'h0, 16'hC000, 16'h0, 16'h0);
        check("post_gnt1", 32'(bus.m_gnt), 32'h2);
        expQ.push_back('{master: 1'b1, data: 16'h00AA});

        for (int i = 0; i < 3; i++) begin
            go(1'b0, 2'b00, 2'b00, 16'h0, 16'h0, 16'h0, 16'h0);
        end
        check("queue_drained", 32'(expQ.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
